tappy_tx: RTL
=============

Name: tappy_tx

Overview:
- Upstream stage of the tappy receiver: serializes bytes into the two-wire clk/dat frame that tappy samples on sysclk.
- Replaces the behavioural stimulus generator with synthesizable RTL for closed-loop benches and FPGA loopback.
- Runs entirely on sysclk, which is at least 4x the maximum line clock of 16.667 kHz. Line clock = sysclk / (2*HALF_TICKS).

Parameters:
- HALF_TICKS, 3, sysclk cycles per line-clock half period. Legal range ≥2. Default gives about 11.1 kHz, inside the 10–16.667 kHz window.
- GAP_TICKS, 6, sysclk cycles of idle (clk=1, dat=1) after each stop bit. Legal range ≥1.

Ports:
- sysclk  in  1  system clock; all state on its posedge.
- reset  in  1  asynchronous, active-low reset.
- data  in  8  byte to send.
- valid  in  1  data is offered.
- bad_parity  in  1  sampled with data; inverts the parity bit of that frame (error injection).
- ready  out  1  block can accept a byte this cycle.
- busy  out  1  frame or gap in progress.
- clk  out  1  line clock; idle high.
- dat  out  1  line data; idle high.

Behaviour:
- Reset (reset=0, asynchronous):
  - clk=1, dat=1, ready=0, busy=0.
  - State IDLE, counters cleared.
  - Applies immediately, including mid-frame; no partial frame resumes.
  - First cycle after release: ready=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Frame format, 11 bits:
  - start bit 0.
  - data[0]..data[7], LSB first.
  - parity = ~^data ^ bad_parity_latched, giving odd parity when bad_parity=0.
  - stop bit 1.
- Handshake:
  - Transfer occurs when valid && ready at a posedge (E0).
  - data and bad_parity are latched at E0.
  - ready=0 and busy=1 from E0+1.
  - valid while ready=0 is ignored; nothing is queued.
- States: IDLE → HIGH → LOW → (HIGH for the next bit | GAP after bit 10) → IDLE.
  - HIGH: dat = current bit, clk=1, for HALF_TICKS cycles. dat changes only on entry to HIGH, so it is stable for the whole high phase.
  - LOW: clk=0, dat held, for HALF_TICKS cycles. The falling edge at HIGH→LOW is the receiver's sample point.
  - GAP: clk=1, dat=1, for GAP_TICKS cycles.
  - GAP→IDLE: ready=1 and busy=0 in the first IDLE cycle.
- Timing:
  - Frame occupies 22*HALF_TICKS cycles, from E0+1 to the end of the last LOW phase.
  - Minimum spacing between accepts: 22*HALF_TICKS + GAP_TICKS + 1 cycles. With defaults this is 73.
- Counters:
  - tick counter width $clog2(max(HALF_TICKS,GAP_TICKS)+1); counts down and reloads on each state change.
  - bit index 0..10; wraps to 0 on leaving GAP.
- Simultaneous events: valid asserted in the same cycle GAP→IDLE occurs is not accepted. The earliest accept is the first cycle in which ready=1.

Decomposition:
- Shared package tappy_pkg:
  - FRAME_BITS=11, START_BIT=0, STOP_BIT=1.
  - State enum {IDLE, HIGH, LOW, GAP}.
  - Function odd_parity(byte) returning ~^b, also reused by the receiver and the bench scoreboard.
- Sub-module tappy_tx_frame: builds the 11-bit shift vector from data and bad_parity. The FSM, tick counter and bit index remain in tappy_tx.

Test Plan:
- data=0xA5, valid one cycle, defaults → dat over the 11 falling edges = 0,1,0,1,0,0,1,0,1,1,1 (parity 1). Frame lasts 66 cycles. ready returns 73 cycles after E0. tappy reports word=0xA5.
- Parity sweep: 0x00 → parity 1; 0x01 → parity 0; 0xFF → parity 1. Each checked at falling edge 10, and tappy word matches each byte.
- bad_parity=1 with 0x3C → parity bit 0 instead of 1. Receiver flags or drops the frame, no done with word=0x3C; the next clean byte 0x55 is received correctly.
- valid held high continuously with data cycling 0x10, 0x11 → exactly one accept per 73 cycles. Bytes changed while busy are not sent. Receiver sees 0x10 then 0x11.
- reset pulsed low at cycle 30 of a 0xC3 frame → clk=1 and dat=1 within the same sysclk phase. ready=1 one cycle after release. Next byte 0x7E is received intact.
- HALF_TICKS=2, GAP_TICKS=1 → line period 4 sysclk (16.667 kHz at the bench sysclk). Bytes 0x00..0xFF sent back-to-back all match in tappy.

Source files
------------

// File: rtl/tappy_pkg.sv
// Shared definitions for the tappy line transmitter, receiver and bench.
package tappy_pkg;

   localparam int         FRAME_BITS   = 11;
   localparam logic       START_BIT    = 1'b0;
   localparam logic       STOP_BIT     = 1'b1;
   localparam logic [3:0] LAST_BIT_IDX = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      GAP  = 2'd3
   } tx_state_e;

   // Parity bit that makes the nine data+parity bits carry an odd count of ones.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/tappy_tx_frame.sv
// Builds the 11-bit frame, bit 0 first on the line:
// start, data LSB..MSB, parity (optionally corrupted), stop.
module tappy_tx_frame
   import tappy_pkg::*;
(
   input  logic [7:0]            data,
   input  logic                  bad_parity,
   output logic [FRAME_BITS-1:0] frame
);

   // Assemble the shift vector; bad_parity flips the parity bit for error injection.
   always_comb begin
      frame = {STOP_BIT, odd_parity(data) ^ bad_parity, data, START_BIT};
   end

endmodule

// File: rtl/tappy_tx.sv
// Serializer for the two-wire tappy clk/dat line, running entirely on sysclk.
// Every output is a flop; the next-state and output logic look one cycle ahead.
module tappy_tx
   import tappy_pkg::*;
#(
   parameter int HALF_TICKS = 3,
   parameter int GAP_TICKS  = 6
)
(
   input  logic       sysclk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   input  logic       bad_parity,
   output logic       ready,
   output logic       busy,
   output logic       clk,
   output logic       dat
);

   localparam int MAX_TICKS = (HALF_TICKS > GAP_TICKS) ? HALF_TICKS : GAP_TICKS;
   localparam int TW        = $clog2(MAX_TICKS + 1);

   localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_TICKS - 1);
   localparam logic [TW-1:0] GAP_RELOAD  = TW'(GAP_TICKS - 1);
   localparam logic [TW-1:0] TICK_ZERO   = TW'(0);
   localparam logic [TW-1:0] TICK_ONE    = TW'(1);

   tx_state_e             state_q, state_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [3:0]            bit_q, bit_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  clk_q, clk_d;
   logic                  dat_q, dat_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic [FRAME_BITS-1:0] frame_s;
   logic                  accept_s;

   tappy_tx_frame u_frame (
      .data       (data),
      .bad_parity (bad_parity),
      .frame      (frame_s)
   );

   // Handshake uses the registered ready, so a byte offered on the GAP->IDLE cycle is ignored.
   always_comb begin
      if (valid && ready_q) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // State, tick counter, bit index and frame capture; counters reload on every state change.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = HIGH;
               tick_d  = HALF_RELOAD;
               bit_d   = 4'd0;
               shift_d = frame_s;
            end else begin
               state_d = IDLE;
            end
         end
         HIGH: begin
            if (tick_q == TICK_ZERO) begin
               state_d = LOW;
               tick_d  = HALF_RELOAD;
            end else begin
               tick_d = tick_q - TICK_ONE;
            end
         end
         LOW: begin
            if (tick_q == TICK_ZERO) begin
               if (bit_q == LAST_BIT_IDX) begin
                  state_d = GAP;
                  tick_d  = GAP_RELOAD;
               end else begin
                  state_d = HIGH;
                  tick_d  = HALF_RELOAD;
                  bit_d   = bit_q + 4'd1;
               end
            end else begin
               tick_d = tick_q - TICK_ONE;
            end
         end
         GAP: begin
            if (tick_q == TICK_ZERO) begin
               state_d = IDLE;
               tick_d  = TICK_ZERO;
               bit_d   = 4'd0;
            end else begin
               tick_d = tick_q - TICK_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = TICK_ZERO;
            bit_d   = 4'd0;
         end
      endcase
   end

   // Line outputs for the coming cycle; dat only picks a new bit when the state is HIGH.
   always_comb begin
      clk_d   = 1'b1;
      dat_d   = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      case (state_d)
         IDLE: begin
            ready_d = 1'b1;
         end
         HIGH: begin
            busy_d = 1'b1;
            dat_d  = shift_d[bit_d];
         end
         LOW: begin
            busy_d = 1'b1;
            clk_d  = 1'b0;
            dat_d  = dat_q;
         end
         GAP: begin
            busy_d = 1'b1;
         end
         default: begin
            ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset idles the line immediately and abandons any frame.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tick_q  <= TICK_ZERO;
         bit_q   <= 4'd0;
         shift_q <= {FRAME_BITS{1'b1}};
         clk_q   <= 1'b1;
         dat_q   <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         clk_q   <= clk_d;
         dat_q   <= dat_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign clk   = clk_q;
   assign dat   = dat_q;

endmodule
